fir_conv_mc: RTL and testbench
==============================

Name: fir_conv_mc

Overview:
- Multi-channel, runtime-programmable FIR convolution engine.
- Successor to the single-channel fixed-coefficient convolution block. Adds:
  - a valid/ready stream handshake on input and output;
  - independent per-channel delay lines sharing one coefficient set;
  - a coefficient write port;
  - a programmable rounding right-shift with saturation.
- Sits between the sample source and the output writer in the filter datapath.
- Uses one multiply-accumulate per cycle, sequenced by an FSM.

Parameters:
- DATA_WIDTH, 16: sample, coefficient and output width; signed two's complement.
- N_TAPS, 16: filter length, at least 2.
- N_CHAN, 4: number of time-multiplexed channels, at least 1.
- SHIFT_W, 5: width of the shift control input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_WIDTH  signed input sample.
- s_chan  in  clog2(N_CHAN), min 1  channel of the input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N_TAPS)  tap index k.
- coef_data  in  DATA_WIDTH  signed coefficient h[k].
- coef_err  out  1  one-cycle pulse: a coefficient write was dropped.
- shift  in  SHIFT_W  output right-shift amount; sampled at accept.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the output.
- m_data  out  DATA_WIDTH  signed, rounded, saturated result.
- m_chan  out  clog2(N_CHAN), min 1  channel of m_data.
- m_sat  out  1  high with m_valid when m_data was clipped.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - FSM to IDLE; s_ready=1; m_valid=0; m_data=0; m_chan=0; m_sat=0; coef_err=0;
  - all delay lines and all coefficients to 0; the accumulator to 0.
- Reset mid-operation aborts the computation in flight; no output is produced for it.
- Accumulator width ACC_W = 2*DATA_WIDTH + clog2(N_TAPS). Products are full-precision signed; the sum is exact and never overflows.
- FSM states and transitions:
  - IDLE:
    - s_ready=1.
    - When s_valid & s_ready: shift s_data into delay line d[s_chan]; d[c][0] is the newest sample.
    - In the same cycle, latch s_chan and shift, clear the accumulator and the tap counter k, then go to MAC.
  - MAC:
    - Each cycle: acc += h[k]*d[c][k], k += 1.
    - After k=N_TAPS-1 is accumulated, go to ROUND.
    - Exactly N_TAPS cycles are spent in MAC.
  - ROUND:
    - If shift=0, r=acc.
    - Otherwise r = (acc + 2^(shift-1)) >>> shift (round half up, arithmetic shift).
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - Register m_data, m_chan and m_sat; set m_valid=1; go to OUT.
    - A shift value of ACC_W or more is treated as ACC_W-1.
  - OUT:
    - m_valid=1. m_data, m_chan and m_sat are held stable until m_ready=1.
    - On m_valid & m_ready: clear m_valid, go to IDLE.
- Latency: accept at edge T; m_valid goes high after the edge at T+N_TAPS+1.
- Throughput: at most one sample per N_TAPS+3 cycles when m_ready is held high.
- s_ready is low in MAC, ROUND and OUT. s_data, s_chan and shift are ignored while s_ready=0.
- s_chan >= N_CHAN: the sample is accepted (handshake completes) but discarded. No output is produced, no delay line changes, and the FSM stays in IDLE.
- Coefficient writes:
  - coef_we in IDLE writes h[coef_addr] at that edge.
  - coef_we on the same edge as an accepted sample: the write lands first, so the new coefficient is used for that sample.
  - coef_we outside IDLE is dropped, and coef_err pulses for exactly one cycle.
- Delay lines of channels other than the active one never change.
- The first N_TAPS-1 outputs of a channel after reset use zero history.

Decomposition:
- Package fir_conv_pkg holds:
  - the state enum (IDLE, MAC, ROUND, OUT);
  - a function computing ACC_W from the parameters;
  - a saturate-and-round function, shared with a future parallel variant.
- Natural sub-module: fir_round_sat. It is combinational: acc and shift in; data and sat flag out. It is instantiated in ROUND.
- Delay lines and coefficient storage stay in the top level.

Test Plan:
- Impulse response:
  - Setup: h[k]=k+1, shift=0; chan 0 inputs 1 then 15 zeros.
  - Required: outputs 1,2,...,16 on m_chan=0. Each m_valid arrives N_TAPS+1 cycles after its accept.
- Rounding:
  - Setup: all h=1, shift=2; chan 1 input 3 repeated.
  - Required: the k-th output is round(3k/4) half up, for k=1..16, giving 1,2,2,3,4,5,5,6,7,8,8,9,10,11,11,12. Steady state is 12.
- Saturation:
  - Setup: all h=0x7FFF, shift=0; input 0x7FFF repeated.
  - Required: once the sum exceeds the positive limit, m_data=0x7FFF with m_sat=1.
  - Negative case: input 0x8000 gives 0x8000 with m_sat=1.
- Channel isolation:
  - Setup: interleave chan 0 samples (all 5) and chan 2 samples (all -2); h[0]=1, other taps 0.
  - Required: chan 0 outputs are always 5 and chan 2 outputs are always -2. The m_chan tag matches each output.
- Backpressure and dropped write:
  - Stimulus: hold m_ready=0 for 10 cycles in OUT.
  - Required: m_data is stable, s_ready=0, and no new accept occurs.
  - Stimulus: assert coef_we during MAC.
  - Required: coef_err pulses for one cycle and the coefficient is unchanged.
- Reset mid-MAC:
  - Stimulus: assert rst during MAC, then release.
  - Required: m_valid never rises for the aborted sample. The next impulse reproduces the zero-history, zero-coefficient response, i.e. all outputs 0.

Source files
------------

// File: rtl/fir_conv_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR convolution engine.
// round_sat works on a 64-bit signed container so one body serves any ACC_W up to 62.
package fir_conv_pkg;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

   typedef logic signed [63:0] wide_t;

   typedef struct packed {
      wide_t val;
      logic  sat;
   } rs_t;

   function automatic int acc_width(input int dw, input int ntaps);
      return 2*dw + $clog2(ntaps);
   endfunction

   // Round half up by adding 2^(s-1) before the arithmetic shift, then clip to dw bits.
   function automatic rs_t round_sat(input wide_t acc, input int sh, input int accw, input int dw);
      rs_t   r;
      wide_t v;
      wide_t maxv;
      wide_t minv;
      int    s;
      s = (sh >= accw) ? accw - 1 : sh;
      if (s == 0) v = acc;
      else        v = (acc + (wide_t'(1) <<< (s - 1))) >>> s;
      maxv = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      minv = -maxv - wide_t'(1);
      if (v > maxv) begin
         r.val = maxv;
         r.sat = 1'b1;
      end else if (v < minv) begin
         r.val = minv;
         r.sat = 1'b1;
      end else begin
         r.val = v;
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational rounding right-shift with saturation of the exact accumulator.
module fir_round_sat
   import fir_conv_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_W      = 36,
   parameter int SHIFT_W    = 5
) (
   input  logic signed [ACC_W-1:0]      i_acc,
   input  logic        [SHIFT_W-1:0]    i_shift,
   output logic signed [DATA_WIDTH-1:0] o_data,
   output logic                         o_sat
);

   rs_t w_rs;

   assign w_rs   = round_sat(wide_t'(i_acc), int'(i_shift), ACC_W, DATA_WIDTH);
   assign o_data = DATA_WIDTH'(w_rs.val);
   assign o_sat  = w_rs.sat;

endmodule

// File: rtl/fir_conv_mc.sv
// Multi-channel programmable FIR: per-channel delay lines, shared coefficients,
// one MAC per cycle, valid/ready stream in and out.
module fir_conv_mc
   import fir_conv_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int N_TAPS     = 16,
   parameter  int N_CHAN     = 4,
   parameter  int SHIFT_W    = 5,
   localparam int CW         = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
   localparam int KW         = $clog2(N_TAPS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic        [CW-1:0]         s_chan,
   input  logic                         coef_we,
   input  logic        [KW-1:0]         coef_addr,
   input  logic signed [DATA_WIDTH-1:0] coef_data,
   output logic                         coef_err,
   input  logic        [SHIFT_W-1:0]    shift,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_data,
   output logic        [CW-1:0]         m_chan,
   output logic                         m_sat
);

   localparam int          ACC_W = acc_width(DATA_WIDTH, N_TAPS);
   localparam logic [CW:0] NCH   = (CW+1)'(N_CHAN);

   state_t r_state, w_next;

   logic [N_TAPS-1:0][DATA_WIDTH-1:0]             r_coef;
   logic [N_CHAN-1:0][N_TAPS-1:0][DATA_WIDTH-1:0] r_dly;
   logic        [CW-1:0]         r_chan;
   logic        [KW-1:0]         r_k;
   logic        [SHIFT_W-1:0]    r_shift;
   logic signed [ACC_W-1:0]      r_acc;
   logic signed [DATA_WIDTH-1:0] r_m_data;
   logic        [CW-1:0]         r_m_chan;
   logic                         r_m_sat;
   logic                         r_coef_err;

   logic                           w_accept;
   logic                           w_start;
   logic                           w_last;
   logic signed [2*DATA_WIDTH-1:0] w_prod;
   logic signed [DATA_WIDTH-1:0]   w_rnd_data;
   logic                           w_rnd_sat;

   // Out-of-range channels complete the handshake but never start a computation.
   assign w_accept = s_valid & s_ready;
   assign w_start  = w_accept & ({1'b0, s_chan} < NCH);
   assign w_last   = (r_k == KW'(N_TAPS - 1));
   assign w_prod   = $signed(r_coef[r_k]) * $signed(r_dly[r_chan][r_k]);

   fir_round_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .SHIFT_W    (SHIFT_W)
   ) u_round_sat (
      .i_acc   (r_acc),
      .i_shift (r_shift),
      .o_data  (w_rnd_data),
      .o_sat   (w_rnd_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_MAC;
         S_MAC:   if (w_last)  w_next = S_ROUND;
         S_ROUND: w_next = S_OUT;
         S_OUT:   if (m_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (r_state == S_IDLE);
      m_valid = (r_state == S_OUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_coef     <= '0;
         r_dly      <= '0;
         r_chan     <= '0;
         r_k        <= '0;
         r_shift    <= '0;
         r_acc      <= '0;
         r_m_data   <= '0;
         r_m_chan   <= '0;
         r_m_sat    <= 1'b0;
         r_coef_err <= 1'b0;
      end else begin
         r_coef_err <= coef_we && (r_state != S_IDLE);
         if (coef_we && (r_state == S_IDLE)) begin
            for (int k = 0; k < N_TAPS; k++)
               if (coef_addr == KW'(k)) r_coef[k] <= coef_data;
         end
         if (w_start) begin
            for (int c = 0; c < N_CHAN; c++)
               if (s_chan == CW'(c)) r_dly[c] <= {r_dly[c][N_TAPS-2:0], s_data};
            r_chan  <= s_chan;
            r_shift <= shift;
            r_acc   <= '0;
            r_k     <= '0;
         end
         if (r_state == S_MAC) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_k   <= r_k + KW'(1);
         end
         if (r_state == S_ROUND) begin
            r_m_data <= w_rnd_data;
            r_m_chan <= r_chan;
            r_m_sat  <= w_rnd_sat;
         end
      end
   end

   assign m_data   = r_m_data;
   assign m_chan   = r_m_chan;
   assign m_sat    = r_m_sat;
   assign coef_err = r_coef_err;

endmodule

// File: tb/tb_fir_conv_mc.sv
// Directed bench for fir_conv_mc: expected outputs are queued at issue, a monitor pops and compares.
module tb_fir_conv_mc;

   localparam int DW = 16;
   localparam int NT = 16;
   localparam int NC = 3;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [1:0]    s_chan;
   logic          coef_we;
   logic [3:0]    coef_addr;
   logic [DW-1:0] coef_data;
   logic          coef_err;
   logic [SW-1:0] shift;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [1:0]    m_chan;
   logic          m_sat;

   fir_conv_mc #(.DATA_WIDTH(DW), .N_TAPS(NT), .N_CHAN(NC), .SHIFT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
      .shift(shift),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_sat(m_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    c;
      logic          s;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   logic prev_v   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [1:0] c, input logic s);
      exp_t e;
      e.d = d; e.c = c; e.s = s;
      q.push_back(e);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++; failures++;
         $display("FAIL %s_timeout: s_ready=%0b required 1", nm, s_ready);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [1:0] c, input logic [SW-1:0] sh);
      wait_idle("send");
      s_valid = 1'b1; s_data = d; s_chan = c; shift = sh;
      @(posedge clk); #1;
      acc_cyc = cyc;
      s_valid = 1'b0;
   endtask

   task automatic wr_coef(input logic [3:0] a, input logic [DW-1:0] d);
      wait_idle("coef");
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
   endtask

   // Monitor: every delivered output must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (m_valid && !prev_v) chk("latency", 32'(cyc - acc_cyc), 32'(NT + 1));
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_out: data=%0h chan=%0d with no output expected", m_data, m_chan);
            end else begin
               e = q.pop_front();
               chk("out_data", 32'(m_data), 32'(e.d));
               chk("out_chan", 32'(m_chan), 32'(e.c));
               chk("out_sat",  32'(m_sat),  32'(e.s));
            end
         end
      end
      prev_v = m_valid;
   end

   int rtab[18] = '{1,2,2,3,4,5,5,6,7,8,8,9,10,11,11,12,12,12};

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_chan = '0; shift = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 1);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_chan", 32'(m_chan), 0);
      chk("rst_m_sat", 32'(m_sat), 0);
      chk("rst_coef_err", 32'(coef_err), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Impulse response
      for (int k = 0; k < NT; k++) wr_coef(4'(k), 16'(k + 1));
      for (int i = 0; i < NT; i++) begin
         push(16'(i + 1), 2'd0, 1'b0);
         send((i == 0) ? 16'd1 : 16'd0, 2'd0, 5'd0);
      end

      // Rounding, all taps 1, shift 2
      for (int k = 0; k < NT; k++) wr_coef(4'(k), 16'd1);
      for (int i = 0; i < 18; i++) begin
         push(16'(rtab[i]), 2'd1, 1'b0);
         send(16'd3, 2'd1, 5'd2);
      end

      // Saturation on chan 1 (history: sixteen 3s)
      for (int k = 0; k < NT; k++) wr_coef(4'(k), 16'h7fff);
      push(16'h7fff, 2'd1, 1'b1); send(16'h7fff, 2'd1, 5'd0);
      push(16'h7fff, 2'd1, 1'b1); send(16'h8000, 2'd1, 5'd0);
      push(16'h8000, 2'd1, 1'b1); send(16'h8000, 2'd1, 5'd0);

      // Channel isolation with h = {1, 0, ...}
      wr_coef(4'd0, 16'd1);
      for (int k = 1; k < NT; k++) wr_coef(4'(k), 16'd0);
      for (int i = 0; i < 4; i++) begin
         push(16'd5, 2'd0, 1'b0);      send(16'd5, 2'd0, 5'd0);
         push(16'hfffe, 2'd2, 1'b0);   send(16'hfffe, 2'd2, 5'd0);
      end
      drain();
      send(16'd9, 2'd3, 5'd0);
      @(negedge clk);
      chk("bad_chan_stays_idle", 32'(s_ready), 1);

      // Backpressure: output held, no new accept
      drain();
      m_ready = 1'b0;
      push(16'd5, 2'd0, 1'b0);
      send(16'd5, 2'd0, 5'd0);
      begin
         int n = 0;
         while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      chk("bp_valid_rise", 32'(m_valid), 1);
      s_valid = 1'b1; s_data = 16'd99; s_chan = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data", 32'(m_data), 5);
         chk("bp_valid", 32'(m_valid), 1);
         chk("bp_s_ready", 32'(s_ready), 0);
      end
      s_valid = 1'b0;
      @(posedge clk); #1 m_ready = 1'b1;

      // Coefficient write during MAC is dropped
      push(16'd5, 2'd0, 1'b0);
      send(16'd5, 2'd0, 5'd0);
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd7;
      @(posedge clk); #1 coef_we = 1'b0;
      @(negedge clk);
      chk("coef_err_pulse", 32'(coef_err), 1);
      @(negedge clk);
      chk("coef_err_clear", 32'(coef_err), 0);
      push(16'd5, 2'd0, 1'b0);
      send(16'd5, 2'd0, 5'd0);

      // Reset mid-MAC aborts the computation
      drain();
      send(16'd5, 2'd0, 5'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_m_valid", 32'(m_valid), 0);
      chk("midrst_s_ready", 32'(s_ready), 1);
      chk("midrst_m_data", 32'(m_data), 0);
      for (int i = 0; i < 4; i++) begin
         push(16'd0, 2'd0, 1'b0);
         send((i == 0) ? 16'd1 : 16'd0, 2'd0, 5'd0);
      end

      drain();
      repeat (5) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
